// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler - radix-2 DIT address sequencer with fixed-latency write-back.
// Optional FFT_SCHED_ABORT_EN adds an abort input that cancels the transform.
module fft_butterfly_scheduler #(
  parameter int LOG2_N   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FFT_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [LOG2_N-1:0] stage,
  output logic              rd_en,
  output logic [LOG2_N-1:0] rd_addr_n,
  output logic [LOG2_N-1:0] rd_addr_m,
  output logic [LOG2_N-2:0] tw_addr,
  output logic              wr_en,
  output logic [LOG2_N-1:0] wr_addr_n,
  output logic [LOG2_N-1:0] wr_addr_m
);

  localparam int KW = LOG2_N - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [KW-1:0]     LAST_K = KW'((2 ** KW) - 1);
  localparam logic [DW-1:0]     LAST_D = DW'(PIPE_LAT - 1);
  localparam logic [LOG2_N-1:0] LAST_S = LOG2_N'(LOG2_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LOG2_N-1:0] s_q;
  logic [KW-1:0]     k_q;
  logic [DW-1:0]     d_q;
  logic              abort_hit;
  logic              abort_cut;

`ifdef FFT_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign abort_cut = abort_hit && (state_q == S_ISSUE || state_q == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (k_q == LAST_K) state_d = S_DRAIN;
      S_DRAIN: if (d_q == LAST_D) state_d = (s_q == LAST_S) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_cut) state_d = S_IDLE;
  end

  // k wraps to zero naturally after the last butterfly of a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      k_q <= '0;
      d_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            s_q <= '0;
            k_q <= '0;
            d_q <= '0;
          end
        end
        S_ISSUE: begin
          k_q <= k_q + KW'(1);
          d_q <= '0;
        end
        S_DRAIN: begin
          d_q <= d_q + DW'(1);
          if (d_q == LAST_D && s_q != LAST_S) begin
            s_q <= s_q + LOG2_N'(1);
            k_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [LOG2_N-1:0] k_ext, half, mask, n_addr;
  logic [KW-1:0]     j_k, tw_raw;

  // Address n is k with a zero bit inserted at position s; m sets that bit.
  always_comb begin
    k_ext  = {1'b0, k_q};
    half   = LOG2_N'(1) << s_q;
    mask   = half - LOG2_N'(1);
    n_addr = ((k_ext >> s_q) << (s_q + LOG2_N'(1))) | (k_ext & mask);
    j_k    = k_q & mask[KW-1:0];
    tw_raw = j_k << (LOG2_N'(KW) - s_q);
  end

  assign rd_en     = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign stage     = s_q;
  assign rd_addr_n = rd_en ? n_addr : '0;
  assign rd_addr_m = rd_en ? (n_addr | half) : '0;
  assign tw_addr   = rd_en ? tw_raw : '0;

  logic [PIPE_LAT-1:0] vld_q;
  logic [LOG2_N-1:0]   an_q [PIPE_LAT];
  logic [LOG2_N-1:0]   am_q [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        an_q[i] <= '0;
        am_q[i] <= '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        an_q[i]  <= an_q[i-1];
        am_q[i]  <= am_q[i-1];
      end
      vld_q[0] <= rd_en;
      an_q[0]  <= rd_addr_n;
      am_q[0]  <= rd_addr_m;
      if (abort_cut) vld_q <= '0;
    end
  end

  assign wr_en     = vld_q[PIPE_LAT-1];
  assign wr_addr_n = wr_en ? an_q[PIPE_LAT-1] : '0;
  assign wr_addr_m = wr_en ? am_q[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// tb_fft_butterfly_scheduler - scoreboard bench for the default 16-point, 3-cycle-latency scheduler.
module tb_fft_butterfly_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] stage, rd_addr_n, rd_addr_m, wr_addr_n, wr_addr_m;
  logic [2:0] tw_addr;
`ifdef FFT_SCHED_ABORT_EN
  logic       abort;
`endif

  fft_butterfly_scheduler #(.LOG2_N(4), .PIPE_LAT(3)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef FFT_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .stage(stage),
    .rd_en(rd_en),
    .rd_addr_n(rd_addr_n),
    .rd_addr_m(rd_addr_m),
    .tw_addr(tw_addr),
    .wr_en(wr_en),
    .wr_addr_n(wr_addr_n),
    .wr_addr_m(wr_addr_m)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int n;
    int m;
    int tw;
    int st;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  rise_q[$];
  int  fall_q[$];

  // Hand-derived operand n and twiddle index for stages 0..3, k = 0..7.
  int exp_n [32] = '{0, 2, 4, 6, 8, 10, 12, 14,
                     0, 1, 4, 5, 8, 9, 12, 13,
                     0, 1, 2, 3, 8, 9, 10, 11,
                     0, 1, 2, 3, 4, 5, 6, 7};
  int exp_tw [32] = '{0, 0, 0, 0, 0, 0, 0, 0,
                      0, 4, 0, 4, 0, 4, 0, 4,
                      0, 2, 4, 6, 0, 2, 4, 6,
                      0, 1, 2, 3, 4, 5, 6, 7};
  int exp_off [4] = '{1, 2, 4, 8};

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name);
    total++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  ev_t r;
  ev_t w;
  int  e;
  bit  prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (rd_en) begin
        if (rd_q.size() == 0) fail_evt("rd_en_unexpected");
        else begin
          r = rd_q.pop_front();
          check("rd_cycle", cyc, r.cyc);
          check("rd_addr_n", rd_addr_n, r.n);
          check("rd_addr_m", rd_addr_m, r.m);
          check("tw_addr", tw_addr, r.tw);
          check("stage", stage, r.st);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) fail_evt("wr_en_unexpected");
        else begin
          w = wr_q.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_addr_n", wr_addr_n, w.n);
          check("wr_addr_m", wr_addr_m, w.m);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_evt("done_unexpected");
        else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e);
        end
      end
      if (busy && !prev_busy) begin
        if (rise_q.size() == 0) fail_evt("busy_rise_unexpected");
        else begin
          e = rise_q.pop_front();
          check("busy_rise_cycle", cyc, e);
        end
      end
      if (!busy && prev_busy) begin
        if (fall_q.size() == 0) fail_evt("busy_fall_unexpected");
        else begin
          e = fall_q.pop_front();
          check("busy_fall_cycle", cyc, e);
        end
      end
      prev_busy = busy;
    end
  end

  // Stage period 11 (8 issues + 3 drain); done at 4*11+1 = 45.
  task automatic push_run(input int base, input int last_c, input bit full);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        int idx;
        c   = 1 + s * 11 + k;
        idx = s * 8 + k;
        if (c <= last_c)
          rd_q.push_back('{base + c, exp_n[idx], exp_n[idx] + exp_off[s], exp_tw[idx], s});
        if (c + 3 <= last_c)
          wr_q.push_back('{base + c + 3, exp_n[idx], exp_n[idx] + exp_off[s], 0, 0});
      end
    end
    rise_q.push_back(base + 1);
    if (full) begin
      done_q.push_back(base + 45);
      fall_q.push_back(base + 45);
    end
  endtask

  task automatic begin_run(output int base, input int last_c, input bit full);
    @(posedge clk);
    #1;
    base = cyc;
    push_run(base, last_c, full);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size() + rise_q.size() + fall_q.size()) != 0
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, rd_q.size() + wr_q.size() + done_q.size() + rise_q.size() + fall_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic check_zero(input string name);
    check(name, {rd_en, wr_en, busy, done, stage, rd_addr_n, rd_addr_m, tw_addr,
                 wr_addr_n, wr_addr_m}, 0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;

    begin_run(base, 1000, 1'b1);
    wait_drain("run1_drained", 80);

    begin_run(base, 1000, 1'b1);
    wait_until(base + 20);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("restart_ignored_drained", 80);

    begin_run(base, 14, 1'b0);
    wait_until(base + 15);
    rst = 1'b1;
    #1;
    check_zero("mid_reset_outputs");
    @(posedge clk);
    #1;
    check_zero("held_reset_outputs");
    rst = 1'b0;
    wait_drain("reset_run_drained", 10);

    begin_run(base, 1000, 1'b1);
    wait_drain("post_reset_run_drained", 80);

`ifdef FFT_SCHED_ABORT_EN
    begin_run(base, 10, 1'b0);
    fall_q.push_back(base + 11);
    wait_until(base + 10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_drain("abort_run_drained", 30);

    begin_run(base, 1000, 1'b1);
    wait_drain("post_abort_run_drained", 80);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
